reg_write_queue: RTL and testbench

- Write side of the 32x32 register file; the counterpart to the 32:1 read-select tree.
- Accepts register write requests over a valid/ready handshake and buffers them in a 2-entry in-order queue.
- Drains one entry per cycle through a 5-to-32 one-hot decoder into the register array.
- Exposes every register on a flat bus for the read-select tree. Flags reads that target a register with a still-pending write.

---
 rtl/reg_write_queue_pkg.sv | 19 +
 rtl/reg_write_queue_decoder.sv | 38 +++
 rtl/reg_write_queue.sv | 173 +++++++++++++++++
 tb/tb_reg_write_queue.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_write_queue_pkg.sv
// Shared definitions for the register-file write queue.
// Holds the register-file geometry (data/index limits, register count),
// the queue depth and the queue occupancy states, so that the top module
// and the decoder agree on every width.
package reg_write_queue_pkg;

  localparam int DATA_INDEX_LIMIT     = 31;
  localparam int REG_ADDR_INDEX_LIMIT = 4;
  localparam int NUM_OF_REG           = 32;
  localparam int QUEUE_DEPTH          = 2;

  // Queue occupancy doubles as the FSM state: the encoding is the entry count.
  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_e;

endpackage

// File: rtl/reg_write_queue_decoder.sv
// DECODER_5x32: 5-bit register index to 32-bit one-hot select.
// Built as a binary tree of 1x2 decoders, MSB first, so that it mirrors the
// 32:1 read-select tree and can be reused for read-side enables.
// Ports:
//   idx    in  5   register index
//   onehot out 32  onehot[k] = (idx == k)
module DECODER_1x2 (
  input  logic       en,
  input  logic       sel,
  output logic [1:0] y
);
  assign y = {en & sel, en & ~sel};
endmodule

module DECODER_5x32 (
  input  logic [4:0]  idx,
  output logic [31:0] onehot
);
  // Level l has 2**l enabled nodes, each split by idx[4-l] into two children.
  for (genvar l = 0; l < 5; l++) begin : lvl
    logic [(2**(l+1))-1:0] y;
    for (genvar j = 0; j < 2**l; j++) begin : node
      logic en_s;
      if (l == 0) begin : g_root
        assign en_s = 1'b1;
      end else begin : g_inner
        assign en_s = lvl[l-1].y[j];
      end
      DECODER_1x2 u_dec (
        .en  (en_s),
        .sel (idx[4-l]),
        .y   (y[2*j +: 2])
      );
    end
  end

  assign onehot = lvl[4].y;
endmodule

// File: rtl/reg_write_queue.sv
// reg_write_queue: write side of the 32x32 register file.
// Requests are accepted over a valid/ready handshake into a 2-entry in-order
// queue and drained one per cycle into the register array via a one-hot
// decoder. Register 0 always reads as zero.
// Ports:
//   CLK, RST (async, active low)
//   WR_VALID/WR_READY/WR_ADDR/WR_DATA  write request handshake
//   RD_ADDR   decode-stage read index, used for the hazard flag PEND_HIT
//   REG_FLAT  all registers, register k at [32k+31:32k]
//   COMMIT / COMMIT_ADDR  registered pulse + index of the entry drained
module reg_write_queue
  import reg_write_queue_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_INDEX_LIMIT + 1,
  parameter int ADDR_WIDTH = REG_ADDR_INDEX_LIMIT + 1,
  parameter int DEPTH      = QUEUE_DEPTH
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             WR_VALID,
  output logic                             WR_READY,
  input  logic [ADDR_WIDTH-1:0]            WR_ADDR,
  input  logic [DATA_WIDTH-1:0]            WR_DATA,
  input  logic [ADDR_WIDTH-1:0]            RD_ADDR,
  output logic                             PEND_HIT,
  output logic [DATA_WIDTH*NUM_OF_REG-1:0] REG_FLAT,
  output logic                             COMMIT,
  output logic [ADDR_WIDTH-1:0]            COMMIT_ADDR
);

  q_state_e              state_q, state_d;
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [ADDR_WIDTH-1:0] ent_addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] ent_addr_d [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data_q [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data_d [DEPTH];
  logic [DATA_WIDTH-1:0] regs_q [NUM_OF_REG];
  logic [DATA_WIDTH-1:0] regs_d [NUM_OF_REG];
  logic                  commit_q, commit_d;
  logic [ADDR_WIDTH-1:0] commit_addr_q, commit_addr_d;

  logic                  accept_s;
  logic                  drain_s;
  logic                  head_n_s;
  logic                  pend_s;
  logic [ADDR_WIDTH-1:0] head_addr_s;
  logic [DATA_WIDTH-1:0] head_data_s;
  logic [NUM_OF_REG-1:0] dec_onehot_s;
  logic [NUM_OF_REG-1:0] we_s;

  assign WR_READY    = (state_q != q_state_e'(DEPTH));
  assign accept_s    = WR_VALID & WR_READY;
  // Any queued entry drains at every edge; the queue never holds one back.
  assign drain_s     = (state_q != Q_EMPTY);
  assign head_n_s    = ~head_q;
  assign head_addr_s = ent_addr_q[head_q];
  assign head_data_s = ent_data_q[head_q];
  assign COMMIT      = commit_q;
  assign COMMIT_ADDR = commit_addr_q;

  DECODER_5x32 u_dec (
    .idx    (head_addr_s),
    .onehot (dec_onehot_s)
  );

  assign we_s = dec_onehot_s & {NUM_OF_REG{drain_s}};

  // Occupancy next-state: accept and drain in the same edge keep the count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      Q_EMPTY: state_d = accept_s ? Q_ONE : Q_EMPTY;
      Q_ONE:   state_d = accept_s ? Q_ONE : Q_EMPTY;
      Q_FULL:  state_d = Q_ONE;  // WR_READY is low, so no accept here
      default: state_d = Q_EMPTY;
    endcase
  end

  // Queue storage and pointer updates.
  always_comb begin
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    tail_d     = tail_q;
    head_d     = head_q;
    if (accept_s) begin
      ent_addr_d[tail_q] = WR_ADDR;
      ent_data_d[tail_q] = WR_DATA;
      tail_d             = ~tail_q;
    end else begin
      tail_d = tail_q;
    end
    if (drain_s) begin
      head_d = head_n_s;
    end else begin
      head_d = head_q;
    end
  end

  // Register array write: one strobe per edge; register 0 never stores.
  always_comb begin
    for (int k = 0; k < NUM_OF_REG; k++) begin
      if (k == 0) begin
        regs_d[k] = '0;
      end else if (we_s[k]) begin
        regs_d[k] = head_data_s;
      end else begin
        regs_d[k] = regs_q[k];
      end
    end
  end

  // Commit pulse; the index holds its last value while idle.
  always_comb begin
    commit_d      = drain_s;
    commit_addr_d = commit_addr_q;
    if (drain_s) begin
      commit_addr_d = head_addr_s;
    end else begin
      commit_addr_d = commit_addr_q;
    end
  end

  // Hazard flag: the head entry counts as pending even on its drain cycle.
  always_comb begin
    pend_s = 1'b0;
    if ((state_q != Q_EMPTY) && (ent_addr_q[head_q] == RD_ADDR)) begin
      pend_s = 1'b1;
    end else if ((state_q == Q_FULL) && (ent_addr_q[head_n_s] == RD_ADDR)) begin
      pend_s = 1'b1;
    end else begin
      pend_s = 1'b0;
    end
  end

  assign PEND_HIT = pend_s & (RD_ADDR != '0);

  for (genvar k = 0; k < NUM_OF_REG; k++) begin : g_flat
    assign REG_FLAT[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
  end

  // State, queue, register array and commit flops.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= Q_EMPTY;
      head_q        <= 1'b0;
      tail_q        <= 1'b0;
      commit_q      <= 1'b0;
      commit_addr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= '0;
        ent_data_q[i] <= '0;
      end
      for (int k = 0; k < NUM_OF_REG; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      commit_q      <= commit_d;
      commit_addr_q <= commit_addr_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= ent_addr_d[i];
        ent_data_q[i] <= ent_data_d[i];
      end
      for (int k = 0; k < NUM_OF_REG; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

endmodule

// File: tb/tb_reg_write_queue.sv
module tb_reg_write_queue;

  logic          CLK;
  logic          RST;
  logic          WR_VALID;
  logic          WR_READY;
  logic [4:0]    WR_ADDR;
  logic [31:0]   WR_DATA;
  logic [4:0]    RD_ADDR;
  logic          PEND_HIT;
  logic [1023:0] REG_FLAT;
  logic          COMMIT;
  logic [4:0]    COMMIT_ADDR;

  int errors = 0;
  int checks = 0;

  // Reference model: a FIFO of pending writes plus the architectural registers.
  logic [4:0]  m_qa [$];
  logic [31:0] m_qd [$];
  logic [31:0] m_regs [32];
  logic        exp_commit;
  logic [4:0]  exp_caddr;
  logic        exp_pend, exp_ready, obs_pend, obs_ready;

  reg_write_queue dut (
    .CLK         (CLK),
    .RST         (RST),
    .WR_VALID    (WR_VALID),
    .WR_READY    (WR_READY),
    .WR_ADDR     (WR_ADDR),
    .WR_DATA     (WR_DATA),
    .RD_ADDR     (RD_ADDR),
    .PEND_HIT    (PEND_HIT),
    .REG_FLAT    (REG_FLAT),
    .COMMIT      (COMMIT),
    .COMMIT_ADDR (COMMIT_ADDR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [1023:0] exp_flat();
    logic [1023:0] f;
    for (int k = 0; k < 32; k++) f[k*32 +: 32] = m_regs[k];
    return f;
  endfunction

  task automatic model_reset();
    m_qa.delete();
    m_qd.delete();
    for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
    exp_commit = 1'b0;
    exp_caddr  = 5'd0;
  endtask

  // One clock: drive, sample pre-edge outputs at negedge, step model at posedge.
  task automatic cycle(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] rd);
    logic [4:0]  ca;
    logic [31:0] cd;
    logic        rdy;
    WR_VALID = v; WR_ADDR = a; WR_DATA = d; RD_ADDR = rd;
    @(negedge CLK);
    obs_pend  = PEND_HIT;
    obs_ready = WR_READY;
    exp_pend  = 1'b0;
    if (rd != 5'd0) foreach (m_qa[i]) if (m_qa[i] == rd) exp_pend = 1'b1;
    rdy       = (m_qa.size() < 2);
    exp_ready = rdy;
    @(posedge CLK);
    exp_commit = 1'b0;
    if (m_qa.size() > 0) begin
      ca = m_qa.pop_front();
      cd = m_qd.pop_front();
      if (ca != 5'd0) m_regs[ca] = cd;
      exp_commit = 1'b1;
      exp_caddr  = ca;
    end
    if (v && rdy) begin
      m_qa.push_back(a);
      m_qd.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    RST = 1'b0; WR_VALID = 1'b1; WR_ADDR = 5'd3; WR_DATA = 32'hDEAD_BEEF; RD_ADDR = 5'd3;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1; WR_VALID = 1'b0;
    #1;
    checks++; if (REG_FLAT !== 1024'd0) begin errors++; $display("FAIL reset_flat: got %0h expected 0", REG_FLAT); end
    checks++; if (WR_READY !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", WR_READY); end
    checks++; if (COMMIT !== 1'b0) begin errors++; $display("FAIL reset_commit: got %0b expected 0", COMMIT); end
    checks++; if (COMMIT_ADDR !== 5'd0) begin errors++; $display("FAIL reset_caddr: got %0d expected 0", COMMIT_ADDR); end
    checks++; if (PEND_HIT !== 1'b0) begin errors++; $display("FAIL reset_pend: got %0b expected 0", PEND_HIT); end
    @(posedge CLK); #1;
    checks++; if (REG_FLAT[127:96] !== 32'd0) begin errors++; $display("FAIL reset_r3: got %0h expected 0", REG_FLAT[127:96]); end
    checks++; if (COMMIT !== 1'b0) begin errors++; $display("FAIL reset_commit2: got %0b expected 0", COMMIT); end
  endtask

  task automatic test_single();
    cycle(1'b1, 5'd5, 32'h1234_5678, 5'd0);
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %0b expected 1", obs_ready); end
    checks++; if (COMMIT !== 1'b0) begin errors++; $display("FAIL single_commit_n: got %0b expected 0", COMMIT); end
    checks++; if (REG_FLAT[191:160] !== 32'd0) begin errors++; $display("FAIL single_early: got %0h expected 0", REG_FLAT[191:160]); end
    cycle(1'b0, 5'd0, 32'd0, 5'd0);
    checks++; if (COMMIT !== 1'b1) begin errors++; $display("FAIL single_commit: got %0b expected 1", COMMIT); end
    checks++; if (COMMIT_ADDR !== 5'd5) begin errors++; $display("FAIL single_caddr: got %0d expected 5", COMMIT_ADDR); end
    checks++; if (REG_FLAT[191:160] !== 32'h1234_5678) begin errors++; $display("FAIL single_r5: got %0h expected 12345678", REG_FLAT[191:160]); end
    checks++; if (REG_FLAT !== exp_flat()) begin errors++; $display("FAIL single_flat: got %0h expected %0h", REG_FLAT, exp_flat()); end
    cycle(1'b0, 5'd0, 32'd0, 5'd0);
    checks++; if (COMMIT !== 1'b0) begin errors++; $display("FAIL single_pulse: got %0b expected 0", COMMIT); end
    checks++; if (COMMIT_ADDR !== 5'd5) begin errors++; $display("FAIL single_hold: got %0d expected 5", COMMIT_ADDR); end
  endtask

  task automatic test_r0();
    cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0);
    cycle(1'b0, 5'd0, 32'd0, 5'd0);
    checks++; if (COMMIT !== 1'b1) begin errors++; $display("FAIL r0_commit: got %0b expected 1", COMMIT); end
    checks++; if (COMMIT_ADDR !== 5'd0) begin errors++; $display("FAIL r0_caddr: got %0d expected 0", COMMIT_ADDR); end
    checks++; if (REG_FLAT[31:0] !== 32'd0) begin errors++; $display("FAIL r0_value: got %0h expected 0", REG_FLAT[31:0]); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] got [$];
    logic [4:0] want [3];
    want = '{5'd7, 5'd7, 5'd9};
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: cycle(1'b1, 5'd7, 32'd1, 5'd0);
        1: cycle(1'b1, 5'd7, 32'd2, 5'd0);
        2: cycle(1'b1, 5'd9, 32'd3, 5'd0);
        default: cycle(1'b0, 5'd0, 32'd0, 5'd0);
      endcase
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL b2b_ready: got %0b expected %0b", obs_ready, exp_ready); end
      if (COMMIT === 1'b1) got.push_back(COMMIT_ADDR);
    end
    checks++; if (got.size() !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++; if (got[i] !== want[i]) begin errors++; $display("FAIL b2b_order: got %0d expected %0d", got[i], want[i]); end
    end
    checks++; if (REG_FLAT[255:224] !== 32'd2) begin errors++; $display("FAIL b2b_r7: got %0h expected 2", REG_FLAT[255:224]); end
    checks++; if (REG_FLAT[319:288] !== 32'd3) begin errors++; $display("FAIL b2b_r9: got %0h expected 3", REG_FLAT[319:288]); end
  endtask

  task automatic test_hazard();
    cycle(1'b1, 5'd12, 32'h0000_0055, 5'd12);
    checks++; if (obs_pend !== 1'b0) begin errors++; $display("FAIL haz_before: got %0b expected 0", obs_pend); end
    cycle(1'b0, 5'd0, 32'd0, 5'd12);
    checks++; if (obs_pend !== 1'b1) begin errors++; $display("FAIL haz_pending: got %0b expected 1", obs_pend); end
    cycle(1'b0, 5'd0, 32'd0, 5'd12);
    checks++; if (obs_pend !== 1'b0) begin errors++; $display("FAIL haz_after: got %0b expected 0", obs_pend); end
    cycle(1'b1, 5'd0, 32'h0000_0077, 5'd0);
    cycle(1'b0, 5'd0, 32'd0, 5'd0);
    checks++; if (obs_pend !== 1'b0) begin errors++; $display("FAIL haz_r0: got %0b expected 0", obs_pend); end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 5'd4, 32'hAAAA_5555, 5'd4);
    WR_VALID = 1'b0;
    #2 RST = 1'b0;
    #1;
    checks++; if (COMMIT !== 1'b0) begin errors++; $display("FAIL mid_commit: got %0b expected 0", COMMIT); end
    checks++; if (PEND_HIT !== 1'b0) begin errors++; $display("FAIL mid_pend: got %0b expected 0", PEND_HIT); end
    @(posedge CLK); #1;
    checks++; if (REG_FLAT[159:128] !== 32'd0) begin errors++; $display("FAIL mid_r4: got %0h expected 0", REG_FLAT[159:128]); end
    checks++; if (COMMIT !== 1'b0) begin errors++; $display("FAIL mid_commit2: got %0b expected 0", COMMIT); end
    @(negedge CLK);
    RST = 1'b1;
    model_reset();
    checks++; if (WR_READY !== 1'b1) begin errors++; $display("FAIL mid_ready: got %0b expected 1", WR_READY); end
    @(posedge CLK); #1;
    checks++; if (COMMIT !== 1'b0) begin errors++; $display("FAIL mid_commit3: got %0b expected 0", COMMIT); end
    checks++; if (REG_FLAT[159:128] !== 32'd0) begin errors++; $display("FAIL mid_r4b: got %0h expected 0", REG_FLAT[159:128]); end
  endtask

  task automatic test_random();
    logic [4:0] prev_a;
    logic [4:0] a, rd;
    prev_a = 5'd1;
    for (int i = 0; i < 300; i++) begin
      a  = 5'($urandom_range(0, 31));
      rd = ($urandom_range(0, 1) == 0) ? prev_a : 5'($urandom_range(0, 31));
      cycle(1'($urandom_range(0, 1)), a, $urandom, rd);
      prev_a = a;
      checks++; if (obs_pend !== exp_pend) begin errors++; $display("FAIL rnd_pend[%0d]: got %0b expected %0b", i, obs_pend, exp_pend); end
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %0b expected %0b", i, obs_ready, exp_ready); end
      checks++; if (COMMIT !== exp_commit) begin errors++; $display("FAIL rnd_commit[%0d]: got %0b expected %0b", i, COMMIT, exp_commit); end
      checks++; if (COMMIT_ADDR !== exp_caddr) begin errors++; $display("FAIL rnd_caddr[%0d]: got %0d expected %0d", i, COMMIT_ADDR, exp_caddr); end
      checks++; if (REG_FLAT !== exp_flat()) begin errors++; $display("FAIL rnd_flat[%0d]: got %0h expected %0h", i, REG_FLAT, exp_flat()); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_r0();
    test_back_to_back();
    test_hazard();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
